// File: rtl/cache_pkg.sv
// Shared L2 cache-model constants and the fill-side state encoding.
package cache_pkg;
    localparam int WAYS_DEFAULT  = 8;
    localparam int BEATS_DEFAULT = 8;

    typedef enum logic {IDLE, FILL} fill_state_t;
endpackage

// File: rtl/way_decoder.sv
// Binary way index plus enable to one-hot way select; inverse of the hit-way encoder.
// Purely combinational; an index >= WAYS or a low enable yields all zeros.
module way_decoder #(
    parameter int WAYS = cache_pkg::WAYS_DEFAULT,
    parameter int WIDX = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic [WIDX-1:0] idx,
    input  logic            en,
    output logic [WAYS-1:0] onehot
);
    // An X on idx makes every compare non-true, so onehot resolves to zeros.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (en && (idx == WIDX'(i)))
                onehot[i] = 1'b1;
        end
    end
endmodule

// File: rtl/way_fill_decoder.sv
// Latches a fill way on req handshake and drives one-hot way_we for each of BEATS beats.
// First write the cycle after accept, done 1 cycle after last write; req_ready low while filling.
module way_fill_decoder
    import cache_pkg::*;
#(
    parameter int WAYS  = WAYS_DEFAULT,
    parameter int BEATS = BEATS_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [$clog2(WAYS)-1:0]   req_way,
    input  logic                      beat_valid,
    output logic [WAYS-1:0]           way_we,
    output logic [$clog2(BEATS)-1:0]  beat_idx,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);
    localparam int WIDX  = $clog2(WAYS);
    localparam int BWIDX = $clog2(BEATS);

    fill_state_t      state;
    logic [WIDX-1:0]  way_q;
    logic [BWIDX-1:0] cnt;
    logic             way_in_range;
    logic             wr_en;

    assign way_in_range = ({1'b0, req_way} < (WIDX+1)'(WAYS));
    assign req_ready    = (state == IDLE);
    assign busy         = (state == FILL);
    assign beat_idx     = cnt;
    assign wr_en        = (state == FILL) && beat_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            way_q <= '0;
            cnt   <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (way_in_range) begin
                            way_q <= req_way;
                            cnt   <= '0;
                            state <= FILL;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    // Terminate explicitly at BEATS-1 so non-power-of-2 BEATS never wraps.
                    if (beat_valid) begin
                        if (cnt == BWIDX'(BEATS - 1)) begin
                            cnt   <= '0;
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    way_decoder #(.WAYS(WAYS), .WIDX(WIDX)) u_dec (
        .idx    (way_q),
        .en     (wr_en),
        .onehot (way_we)
    );
endmodule
